// File: rtl/axi_wr_slave_arbiter.sv
// Per-slave AXI write-path arbiter: round-robin grant held for one
// full AW/W/B transaction, with a watchdog that releases stalled owners.
module axi_wr_slave_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int IDXW        = 2,
  parameter int TIMEOUT     = 1024,
  parameter int TOW         = 11
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   aw_hs,
  input  logic                   w_last_hs,
  input  logic                   b_hs,
  output logic                   grant_valid,
  output logic [IDXW-1:0]        grant_idx,
  output logic [NUM_MASTERS-1:0] grant_onehot,
  output logic [1:0]             state_o,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [TOW-1:0]         wd, wd_n;
  logic [IDXW-1:0]        last, last_n;
  logic                   gv_n;
  logic [IDXW-1:0]        idx_n;
  logic [NUM_MASTERS-1:0] oh_n;
  logic                   to_n;

  logic                   pick_found;
  logic [IDXW-1:0]        pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   wd_hit;
  int                     j;

  // Scan starts one past the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    j          = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = (int'(last) + i) % NUM_MASTERS;
      if (!pick_found && req[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(j);
        pick_oh    = NUM_MASTERS'(1) << j;
      end
    end
  end

  assign wd_hit = (wd == TOW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    last_n  = last;
    gv_n    = grant_valid;
    idx_n   = grant_idx;
    oh_n    = grant_onehot;
    to_n    = 1'b0;
    wd_n    = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = ADDR;
          gv_n    = 1'b1;
          idx_n   = pick_idx;
          oh_n    = pick_oh;
          last_n  = pick_idx;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          state_n = w_last_hs ? RESP : DATA;
        end else if (wd_hit) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
          to_n    = 1'b1;
        end
      end
      DATA: begin
        if (w_last_hs) begin
          state_n = RESP;
        end else if (wd_hit) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
          to_n    = 1'b1;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
        end else if (wd_hit) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
          to_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gv_n    = 1'b0;
        oh_n    = '0;
      end
    endcase
    // Watchdog restarts whenever the state moves.
    if (state_n == state && state != IDLE)
      wd_n = wd + TOW'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= IDLE;
      wd           <= '0;
      last         <= IDXW'(NUM_MASTERS - 1);
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      wd           <= wd_n;
      last         <= last_n;
      grant_valid  <= gv_n;
      grant_idx    <= idx_n;
      grant_onehot <= oh_n;
      timeout_err  <= to_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_axi_wr_slave_arbiter.sv
// Scoreboard bench for axi_wr_slave_arbiter: expected grants are queued
// from a round-robin model and compared when the grant appears.
module tb_axi_wr_slave_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [2:0] req = '0;
  logic       aw_hs = 1'b0;
  logic       w_last_hs = 1'b0;
  logic       b_hs = 1'b0;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [2:0] grant_onehot;
  logic [1:0] state_o;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] mlast;
  logic [1:0] expq[$];
  logic [1:0] exp_idx;

  axi_wr_slave_arbiter #(
    .NUM_MASTERS(3), .IDXW(2), .TIMEOUT(8), .TOW(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req(req),
    .aw_hs(aw_hs), .w_last_hs(w_last_hs), .b_hs(b_hs),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .state_o(state_o),
    .timeout_err(timeout_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [1:0] rr(input logic [2:0] r,
                                    input logic [1:0] l);
    int k;
    for (int i = 1; i <= 3; i++) begin
      k = (int'(l) + i) % 3;
      if (r[k]) return 2'(k);
    end
    return 2'd0;
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_exp();
    mlast = rr(req, mlast);
    expq.push_back(mlast);
  endtask

  task automatic do_reset();
    req = '0;
    aw_hs = 0; w_last_hs = 0; b_hs = 0;
    ARESETn = 0;
    step();
    ARESETn = 1;
    mlast = 2'd2;
    expq.delete();
  endtask

  task automatic run_txn(input int beats);
    aw_hs = 1; step(); aw_hs = 0;
    for (int b = 1; b <= beats; b++) begin
      w_last_hs = (b == beats);
      step();
    end
    w_last_hs = 0;
    b_hs = 1; step(); b_hs = 0;
  endtask

  task automatic check_grant(input string nm);
    exp_idx = expq.pop_front();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_idx !== exp_idx ||
        grant_onehot !== (3'b001 << exp_idx)) begin
      n_fail++;
      $display("FAIL %s: gv=%0b idx=%0d oh=%b want gv=1 idx=%0d oh=%b",
               nm, grant_valid, grant_idx, grant_onehot,
               exp_idx, 3'b001 << exp_idx);
    end
  endtask

  task automatic test_reset();
    ARESETn = 0;
    req = 3'b111;
    step(); step();
    n_checks++;
    if (grant_valid !== 0 || grant_onehot !== 0 ||
        state_o !== 0 || timeout_err !== 0 || grant_idx !== 0) begin
      n_fail++;
      $display("FAIL reset_state: gv=%0b idx=%0d oh=%b st=%0d to=%0b want all 0",
               grant_valid, grant_idx, grant_onehot, state_o, timeout_err);
    end
    ARESETn = 1;
    mlast = 2'd2;
    expq.delete();
    push_exp();
    step();
    check_grant("reset_first_grant");
    run_txn(1);
  endtask

  task automatic test_round_robin();
    int k;
    do_reset();
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      push_exp();
      k = 0;
      step();
      while (!grant_valid && k < 4) begin
        step();
        k++;
      end
      n_checks++;
      if (k !== 0) begin
        n_fail++;
        $display("FAIL rr_latency%0d: extra cycles %0d want 0", t, k);
      end
      check_grant("rr_grant");
      run_txn(4);
      n_checks++;
      if (grant_valid !== 0 || state_o !== 0) begin
        n_fail++;
        $display("FAIL rr_release%0d: gv=%0b st=%0d want 0 0",
                 t, grant_valid, state_o);
      end
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    req = 3'b001;
    push_exp();
    step();
    check_grant("single_grant");
    aw_hs = 1; w_last_hs = 1;
    step();
    aw_hs = 0; w_last_hs = 0;
    n_checks++;
    if (state_o !== 2'd3) begin
      n_fail++;
      $display("FAIL single_resp: state=%0d want 3", state_o);
    end
    b_hs = 1; step(); b_hs = 0;
    n_checks++;
    if (state_o !== 2'd0 || grant_valid !== 0) begin
      n_fail++;
      $display("FAIL single_idle: state=%0d gv=%0b want 0 0",
               state_o, grant_valid);
    end
  endtask

  task automatic test_grant_hold();
    do_reset();
    req = 3'b010;
    push_exp();
    step();
    check_grant("hold_grant");
    aw_hs = 1; step(); aw_hs = 0;
    req = 3'b100;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (grant_valid !== 1 || grant_idx !== 2'd1 ||
          grant_onehot !== 3'b010) begin
        n_fail++;
        $display("FAIL hold_stable%0d: gv=%0b idx=%0d oh=%b want 1 1 010",
                 c, grant_valid, grant_idx, grant_onehot);
      end
    end
    w_last_hs = 1; step(); w_last_hs = 0;
    b_hs = 1; step(); b_hs = 0;
    push_exp();
    step();
    check_grant("hold_next");
    run_txn(1);
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 3'b011;
    push_exp();
    step();
    check_grant("wd_grant");
    for (int c = 1; c <= 7; c++) begin
      step();
      n_checks++;
      if (grant_valid !== 1 || timeout_err !== 0) begin
        n_fail++;
        $display("FAIL wd_early%0d: gv=%0b to=%0b want 1 0",
                 c, grant_valid, timeout_err);
      end
    end
    step();
    n_checks++;
    if (timeout_err !== 1 || grant_valid !== 0 || state_o !== 0) begin
      n_fail++;
      $display("FAIL wd_fire: to=%0b gv=%0b st=%0d want 1 0 0",
               timeout_err, grant_valid, state_o);
    end
    push_exp();
    step();
    n_checks++;
    if (timeout_err !== 0) begin
      n_fail++;
      $display("FAIL wd_pulse: to=%0b want 0", timeout_err);
    end
    check_grant("wd_next");
    for (int c = 1; c <= 7; c++) step();
    aw_hs = 1; step(); aw_hs = 0;
    n_checks++;
    if (state_o !== 2'd2 || timeout_err !== 0 || grant_valid !== 1) begin
      n_fail++;
      $display("FAIL wd_tie: st=%0d to=%0b gv=%0b want 2 0 1",
               state_o, timeout_err, grant_valid);
    end
    w_last_hs = 1; step(); w_last_hs = 0;
    b_hs = 1; step(); b_hs = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b111;
    push_exp();
    step();
    check_grant("ar_grant");
    aw_hs = 1; step(); aw_hs = 0;
    #3 ARESETn = 0;
    #1;
    n_checks++;
    if (grant_valid !== 0 || grant_onehot !== 0 || state_o !== 0) begin
      n_fail++;
      $display("FAIL async_drop: gv=%0b oh=%b st=%0d want 0 000 0",
               grant_valid, grant_onehot, state_o);
    end
    #1 ARESETn = 1;
    mlast = 2'd2;
    expq.delete();
    push_exp();
    step();
    check_grant("ar_next");
    run_txn(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_beat();
    test_grant_hold();
    test_watchdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
